// File: rtl/fifo_read_adapter_16_bit.sv
// ---------------------------------------------------------------------------
// fifo_read_adapter_16_bit
// Pulls words out of a 16-bit synchronous-read FIFO and presents them on a
// valid/ready stream through a 2-entry in-order output buffer. A read issued
// at one edge returns data during the following cycle. That word is captured
// at the next edge, so the buffer reserves a slot for every read in flight.
//
// Ports
//   Clk_In                single clock, rising edge
//   Reset_In              asynchronous active-high reset
//   Enable_In             permits new FIFO reads; buffered words still drain
//   FIFO_Empty_In         FIFO empty flag
//   FIFO_Data_In [15:0]   FIFO read data, valid the cycle after a read edge
//   FIFO_Read_Enable_Out  combinational read strobe to the FIFO
//   M_Data_Out   [15:0]   registered head word of the output buffer
//   M_Valid_Out           registered, high while the buffer is non-empty
//   M_Ready_In            consumer accepts the head word (pop) when valid
//   Words_Read_Count_Out  number of pops since reset, wraps at 2^16
// ---------------------------------------------------------------------------
module fifo_read_adapter_16_bit (
   input  logic        Clk_In,
   input  logic        Reset_In,
   input  logic        Enable_In,
   input  logic        FIFO_Empty_In,
   input  logic [15:0] FIFO_Data_In,
   output logic        FIFO_Read_Enable_Out,
   output logic [15:0] M_Data_Out,
   output logic        M_Valid_Out,
   input  logic        M_Ready_In,
   output logic [15:0] Words_Read_Count_Out
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned OCC_W  = 2;
   localparam int unsigned DEM_W  = 3;
   localparam int unsigned DEPTH  = 2;

   // Buffer state. The head entry is M_Data_Out itself; tail holds entry 1.
   logic [OCC_W-1:0]  occ;
   logic [OCC_W-1:0]  occ_next;
   logic [OCC_W-1:0]  remain_c;
   logic              in_flight;
   logic [DATA_W-1:0] tail;
   logic [DATA_W-1:0] tail_next;
   logic [DATA_W-1:0] head_next;
   logic              pop_c;
   logic [DEM_W-1:0]  demand_c;

   assign pop_c = M_Valid_Out & M_Ready_In;

   // Slots committed after this edge: stored words plus the read in flight,
   // less the word leaving now. A new read is allowed only if one slot is left.
   assign demand_c = DEM_W'(occ) + DEM_W'(in_flight) - DEM_W'(pop_c);

   assign FIFO_Read_Enable_Out = Enable_In & ~FIFO_Empty_In & ~Reset_In &
                                 (demand_c < DEM_W'(DEPTH));

   // Next buffer contents: shift on pop, then append the returning word
   // behind whatever entry remains.
   always_comb begin
      head_next = M_Data_Out;
      tail_next = tail;
      remain_c  = occ - OCC_W'(pop_c);
      if (pop_c) begin
         head_next = tail;
      end
      if (in_flight) begin
         if (remain_c == OCC_W'(0)) begin
            head_next = FIFO_Data_In;
         end else begin
            tail_next = FIFO_Data_In;
         end
      end
      occ_next = remain_c + OCC_W'(in_flight);
   end

   // State registers; reset also drops any read in flight.
   always_ff @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         occ                  <= '0;
         in_flight            <= 1'b0;
         tail                 <= '0;
         M_Data_Out           <= '0;
         M_Valid_Out          <= 1'b0;
         Words_Read_Count_Out <= '0;
      end else begin
         occ         <= occ_next;
         in_flight   <= FIFO_Read_Enable_Out;
         tail        <= tail_next;
         M_Data_Out  <= head_next;
         M_Valid_Out <= (occ_next != OCC_W'(0));
         if (pop_c) begin
            Words_Read_Count_Out <= Words_Read_Count_Out + DATA_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fifo_read_adapter_16_bit.sv
// ---------------------------------------------------------------------------
// tb_fifo_read_adapter_16_bit
// Bench for fifo_read_adapter_16_bit. It models the attached FIFO as an
// array with read/write pointers. A stream scoreboard expects popped words
// in FIFO order and restarts at the FIFO head after each reset. It also
// tracks words outstanding, the pop count and hold stability. Directed
// scenarios come first, then a randomized run.
// ---------------------------------------------------------------------------
module tb_fifo_read_adapter_16_bit;

   localparam int unsigned MEM_N = 4096;

   logic        clk;
   logic        rst;
   logic        en;
   logic        empty;
   logic [15:0] fdata;
   logic        rd;
   logic [15:0] mdata;
   logic        mvalid;
   logic        mready;
   logic [15:0] cnt;

   int unsigned total = 0;
   int unsigned bad   = 0;

   // FIFO model
   logic [15:0] mem [0:MEM_N-1];
   int          wr_ptr = 0;
   int          rd_ptr = 0;

   fifo_read_adapter_16_bit dut (
      .Clk_In               (clk),
      .Reset_In             (rst),
      .Enable_In            (en),
      .FIFO_Empty_In        (empty),
      .FIFO_Data_In         (fdata),
      .FIFO_Read_Enable_Out (rd),
      .M_Data_Out           (mdata),
      .M_Valid_Out          (mvalid),
      .M_Ready_In           (mready),
      .Words_Read_Count_Out (cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign empty = (wr_ptr == rd_ptr);

   // Synchronous-read FIFO: data valid the cycle after the strobe, junk otherwise.
   always @(posedge clk) begin
      if (rd && !empty) begin
         fdata  <= mem[rd_ptr % MEM_N];
         rd_ptr <= rd_ptr + 1;
      end else begin
         fdata <= 16'($urandom);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard and invariant monitor, sampled mid-cycle
   int          issued   = 0;
   int          popped   = 0;
   int          exp_idx  = 0;
   logic [15:0] exp_cnt  = '0;
   logic        prev_rd  = 1'b0;
   logic        hold_q   = 1'b0;
   logic [15:0] hold_data = '0;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_valid", 32'(mvalid), 32'd0);
         chk("rst_data",  32'(mdata),  32'd0);
         chk("rst_count", 32'(cnt),    32'd0);
         chk("rst_rd",    32'(rd),     32'd0);
         issued  = 0;
         popped  = 0;
         exp_cnt = '0;
         exp_idx = rd_ptr;
         prev_rd = 1'b0;
         hold_q  = 1'b0;
      end else begin
         chk("rd_when_empty", 32'(rd & empty), 32'd0);
         chk("outstanding_le2", 32'((issued - popped) <= 2), 32'd1);
         chk("count", 32'(cnt), 32'(exp_cnt));
         // Words that have arrived = reads issued except one still in flight.
         chk("valid", 32'(mvalid), 32'((issued - int'(prev_rd) - popped) > 0));
         if (hold_q) begin
            chk("hold_valid", 32'(mvalid), 32'd1);
            chk("hold_data",  32'(mdata),  32'(hold_data));
         end
         if (mvalid && mready) begin
            chk("order", 32'(mdata), 32'(mem[exp_idx % MEM_N]));
            exp_idx++;
            popped++;
            exp_cnt = exp_cnt + 16'd1;
         end
         hold_q    = mvalid & ~mready;
         hold_data = mdata;
         if (rd) issued++;
         prev_rd = rd;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic push_seq(input int n);
      for (int i = 0; i < n; i++) begin
         mem[wr_ptr % MEM_N] = 16'(16'h1111 * (i + 1));
         wr_ptr++;
      end
   endtask

   task automatic push_rand();
      mem[wr_ptr % MEM_N] = 16'($urandom);
      wr_ptr++;
   endtask

   // Sample n mid-cycle points; report strobe/valid counts and spans.
   task automatic run_count(input int n, output int rds, output int vals,
                            output int f_rd, output int l_rd,
                            output int f_val, output int l_val);
      rds = 0; vals = 0; f_rd = -1; l_rd = -1; f_val = -1; l_val = -1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (rd) begin
            rds++;
            if (f_rd < 0) f_rd = i;
            l_rd = i;
         end
         if (mvalid) begin
            vals++;
            if (f_val < 0) f_val = i;
            l_val = i;
         end
      end
   endtask

   // Reset in mid-stream; afterwards delivery restarts at the FIFO head.
   task automatic reset_mid(input logic rdy_before, input int pre, input string tag);
      int  head;
      bit  seen;
      do_reset();
      mready = rdy_before;
      push_seq(8);
      for (int i = 0; i < pre; i++) step();
      rst = 1'b1;
      @(negedge clk);
      chk({tag, "_now_valid"}, 32'(mvalid), 32'd0);
      chk({tag, "_now_data"},  32'(mdata),  32'd0);
      chk({tag, "_now_count"}, 32'(cnt),    32'd0);
      step();
      step();
      head   = rd_ptr;
      rst    = 1'b0;
      mready = 1'b1;
      seen   = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (mvalid) begin
            seen = 1'b1;
            chk({tag, "_first_word"}, 32'(mdata), 32'(mem[head % MEM_N]));
         end
      end
      chk({tag, "_first_seen"}, 32'(seen), 32'd1);
      @(negedge clk);
      chk({tag, "_count_restart"}, 32'(cnt), 32'd1);
      for (int i = 0; i < 15; i++) step();
      @(negedge clk);
      chk({tag, "_drained"}, 32'(empty & ~mvalid), 32'd1);
   endtask

   initial begin
      int rds, vals, f_rd, l_rd, f_val, l_val;
      rst = 1'b1; en = 1'b1; mready = 1'b1;
      step();
      rst = 1'b0;

      // Empty FIFO: nothing read, nothing valid
      do_reset();
      run_count(10, rds, vals, f_rd, l_rd, f_val, l_val);
      chk("idle_reads", 32'(rds),  32'd0);
      chk("idle_valid", 32'(vals), 32'd0);

      // Streaming 8 words with consumer always ready
      step();
      do_reset();
      push_seq(8);
      run_count(14, rds, vals, f_rd, l_rd, f_val, l_val);
      chk("stream_reads",     32'(rds),                32'd8);
      chk("stream_rd_span",   32'(l_rd - f_rd + 1),    32'd8);
      chk("stream_valids",    32'(vals),               32'd8);
      chk("stream_val_span",  32'(l_val - f_val + 1),  32'd8);
      chk("stream_latency",   32'(f_val - f_rd),       32'd2);
      chk("stream_count",     32'(cnt),                32'd8);

      // Consumer stalled: exactly two reads, head held
      step();
      do_reset();
      mready = 1'b0;
      push_seq(8);
      run_count(10, rds, vals, f_rd, l_rd, f_val, l_val);
      chk("stall_reads", 32'(rds),    32'd2);
      chk("stall_head",  32'(mdata),  32'h1111);
      chk("stall_valid", 32'(mvalid), 32'd1);
      chk("stall_left",  32'(wr_ptr - rd_ptr), 32'd6);
      step();
      mready = 1'b1;
      run_count(16, rds, vals, f_rd, l_rd, f_val, l_val);
      chk("stall_pops",  32'(vals),   32'd8);
      chk("stall_count", 32'(cnt),    32'd8);
      chk("stall_empty", 32'(empty & ~mvalid), 32'd1);

      // Ready toggling 1,0,1,0
      step();
      do_reset();
      push_seq(8);
      for (int i = 0; i < 30; i++) begin
         mready = (i % 2 == 0);
         step();
      end
      @(negedge clk);
      chk("toggle_count", 32'(cnt),    32'd8);
      chk("toggle_valid", 32'(mvalid), 32'd0);

      // Reset with a read in flight, then with a full buffer
      step();
      reset_mid(1'b1, 3, "rst_inflight");
      step();
      reset_mid(1'b0, 6, "rst_full");

      // Enable low: buffered words drain, no new reads
      step();
      do_reset();
      mready = 1'b0;
      push_seq(6);
      for (int i = 0; i < 6; i++) step();
      en = 1'b0;
      mready = 1'b1;
      run_count(6, rds, vals, f_rd, l_rd, f_val, l_val);
      chk("disable_reads", 32'(rds),    32'd0);
      chk("disable_drain", 32'(vals),   32'd2);
      chk("disable_valid", 32'(mvalid), 32'd0);
      chk("disable_left",  32'(wr_ptr - rd_ptr), 32'd4);
      step();
      en = 1'b1;
      for (int i = 0; i < 12; i++) step();
      @(negedge clk);
      chk("disable_resume", 32'(empty & ~mvalid), 32'd1);

      // Randomized traffic, occasional resets
      step();
      for (int i = 0; i < 2000; i++) begin
         en     = ($urandom_range(0, 3) != 0);
         mready = ($urandom_range(0, 4) < 3);
         rst    = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 1) == 1 && (wr_ptr - rd_ptr) < 6) push_rand();
         step();
      end
      rst = 1'b0; en = 1'b1; mready = 1'b1;
      for (int i = 0; i < 20; i++) step();
      @(negedge clk);
      chk("rand_drained", 32'(empty & ~mvalid), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
